// File: rtl/ccff_ctrl_pkg.sv
// Shared types and sizing helpers for the ccff programming sequencer.
package ccff_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } ccff_state_e;

    // Words needed to cover one full pass of the chain.
    function automatic int unsigned ccff_words(input int unsigned chain_len,
                                               input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Useful bits in the final word of a pass.
    function automatic int unsigned ccff_last_bits(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds one bitstream word and presents it LSB-first, one bit per shift.
module ccff_word_serializer
    import ccff_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              shift,
    input  logic              final_word,
    input  logic [WORD_W-1:0] data,
    output logic              held,
    output logic              head_bit,
    output logic              last_bit
);

    localparam int unsigned IDX_W     = $clog2(WORD_W);
    localparam int unsigned LAST_BITS = ccff_last_bits(CHAIN_LEN, WORD_W);

    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  idx_q;
    logic              held_q;

    assign held     = held_q;
    assign head_bit = held_q ? word_q[idx_q] : 1'b0;

    // In the final word of a pass the upper bits are never shifted.
    assign last_bit = held_q && ((idx_q == IDX_W'(WORD_W - 1)) ||
                                 (final_word && (idx_q == IDX_W'(LAST_BITS - 1))));

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            held_q <= 1'b0;
        end else if (flush) begin
            idx_q  <= '0;
            held_q <= 1'b0;
        end else if (load) begin
            word_q <= data;
            idx_q  <= '0;
            held_q <= 1'b1;
        end else if (shift) begin
            if (last_bit) begin
                held_q <= 1'b0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ccff_prog_controller.sv
// Configuration-chain programming sequencer: load pass, optional verify pass,
// fabric clock gating and IO isolation release.
module ccff_prog_controller
    import ccff_ctrl_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = 1024,
    parameter  int unsigned WORD_W    = 32,
    localparam int unsigned IDX_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              prog_clk_en,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  err_idx
);

    localparam int unsigned NWORDS = ccff_words(CHAIN_LEN, WORD_W);
    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WCNT_W = $clog2(NWORDS + 1);

    ccff_state_e       state_q, state_d;
    logic              verify_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [WCNT_W-1:0] word_cnt_q;
    logic              mis_q;
    logic [IDX_W-1:0]  err_idx_q;
    logic              busy_q, done_q, error_q, isol_n_q;

    logic held, head_bit, last_bit;
    logic active_c, shift_c, pass_end_c, final_word_c, more_c;
    logic rdy_c, accept_c, start_ok_c, mis_now_c;

    ccff_word_serializer #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) u_ser (
        .clk        (prog_clk),
        .rst        (prog_reset),
        .flush      (start_ok_c),
        .load       (accept_c),
        .shift      (shift_c),
        .final_word (final_word_c),
        .data       (cfg_data),
        .held       (held),
        .head_bit   (head_bit),
        .last_bit   (last_bit)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_d = ST_LOAD;
            ST_LOAD:   if (pass_end_c) state_d = verify_q ? ST_VERIFY : ST_DONE;
            ST_VERIFY: if (pass_end_c) state_d = (mis_q || mis_now_c) ? ST_ERR : ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Handshake, shift and compare strobes; the word for the verify pass may be
    // taken on the final load bit so the stream has no bubble at the boundary.
    always_comb begin
        active_c     = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
        start_ok_c   = start && !active_c;
        shift_c      = active_c && held;
        pass_end_c   = shift_c && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
        final_word_c = (word_cnt_q == WCNT_W'(NWORDS));
        more_c       = (word_cnt_q < WCNT_W'(NWORDS)) ||
                       (pass_end_c && (state_q == ST_LOAD) && verify_q);
        rdy_c        = active_c && (!held || (shift_c && last_bit)) && more_c;
        accept_c     = rdy_c && cfg_valid;
        mis_now_c    = shift_c && (state_q == ST_VERIFY) && (ccff_tail != head_bit);
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            verify_q   <= 1'b0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            mis_q      <= 1'b0;
            err_idx_q  <= '0;
        end else if (start_ok_c) begin
            verify_q   <= verify;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            mis_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            if (pass_end_c) begin
                bit_cnt_q  <= '0;
                word_cnt_q <= accept_c ? WCNT_W'(1) : '0;
            end else begin
                if (shift_c)  bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                if (accept_c) word_cnt_q <= word_cnt_q + WCNT_W'(1);
            end
            if (mis_now_c && !mis_q) begin
                mis_q     <= 1'b1;
                err_idx_q <= IDX_W'(bit_cnt_q);
            end
        end
    end

    // Status flags follow the state being entered so they change with it.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            isol_n_q <= 1'b0;
        end else begin
            busy_q   <= (state_d == ST_LOAD) || (state_d == ST_VERIFY);
            done_q   <= (state_d == ST_DONE);
            error_q  <= (state_d == ST_ERR);
            isol_n_q <= (state_d == ST_DONE);
        end
    end

    assign cfg_ready   = rdy_c;
    assign ccff_head   = head_bit;
    assign prog_clk_en = shift_c;
    assign IO_ISOL_N   = isol_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_idx     = err_idx_q;

endmodule
